// File: rtl/pitch_pkg.sv
// Pitch constants and elaboration-time helpers for the poly pitch generator.
// The octave-0 frequencies are stored in micro-Hz so the C0 half-period rounds exactly.
package pitch_pkg;

    localparam int N_NOTES = 12;

    localparam logic [3:0] NOTE_C  = 4'd0;
    localparam logic [3:0] NOTE_CS = 4'd1;
    localparam logic [3:0] NOTE_D  = 4'd2;
    localparam logic [3:0] NOTE_DS = 4'd3;
    localparam logic [3:0] NOTE_E  = 4'd4;
    localparam logic [3:0] NOTE_F  = 4'd5;
    localparam logic [3:0] NOTE_FS = 4'd6;
    localparam logic [3:0] NOTE_G  = 4'd7;
    localparam logic [3:0] NOTE_GS = 4'd8;
    localparam logic [3:0] NOTE_A  = 4'd9;
    localparam logic [3:0] NOTE_AS = 4'd10;
    localparam logic [3:0] NOTE_B  = 4'd11;

    function automatic longint f0_uhz(input int note);
        case (note)
            0:       return 64'd16351598;
            1:       return 64'd17323914;
            2:       return 64'd18354048;
            3:       return 64'd19445436;
            4:       return 64'd20601722;
            5:       return 64'd21826764;
            6:       return 64'd23124651;
            7:       return 64'd24499715;
            8:       return 64'd25956544;
            9:       return 64'd27500000;
            10:      return 64'd29135235;
            11:      return 64'd30867706;
            default: return 64'd27500000;
        endcase
    endfunction

    function automatic longint f0_mhz(input int note);
        return (f0_uhz(note) + 64'd500) / 64'd1000;
    endfunction

    function automatic longint half_period(input int note, input int oct, input longint clk_hz);
        longint den;
        longint h;
        den = 2 * f0_uhz(note);
        h   = (clk_hz * 64'd1000000 + den / 2) / den;
        h   = h >> oct;
        if (h < 2) h = 2;
        return h;
    endfunction

endpackage

// File: rtl/pitch_channel.sv
// One square-wave voice: enable, mute, half-period counter and a pending retune
// that is only applied on a wave edge so the output never glitches.
module pitch_channel
    import pitch_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int CNT_W  = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_i,
    input  logic [3:0] note_i,
    input  logic [3:0] oct_i,
    input  logic       en_i,
    output logic       wave_o
);

    logic [15:0][CNT_W-1:0] base;
    logic             en_q, en_d, mute_q, mute_d, wave_q, wave_d, pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       note_q, note_d, oct_q, oct_d, pnote_q, pnote_d, poct_q, poct_d;

    for (genvar i = 0; i < 16; i++) begin : g_base
        assign base[i] = (i < N_NOTES) ? CNT_W'(half_period(i, 0, longint'(CLK_HZ))) : CNT_W'(2);
    end

    function automatic logic [CNT_W-1:0] h_of(input logic [3:0] n, input logic [3:0] o);
        logic [CNT_W-1:0] b;
        b = base[n] >> o;
        if (b < CNT_W'(2)) b = CNT_W'(2);
        return b;
    endfunction

    function automatic logic valid_note(input logic [3:0] n);
        return n < 4'(N_NOTES);
    endfunction

    always_comb begin
        en_d    = en_q;
        mute_d  = mute_q;
        wave_d  = wave_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        note_d  = note_q;
        oct_d   = oct_q;
        pnote_d = pnote_q;
        poct_d  = poct_q;
        // Idle, muted or disabling writes restart the voice immediately.
        if (wr_i && (!en_q || mute_q || !en_i)) begin
            en_d   = en_i;
            mute_d = en_i && !valid_note(note_i);
            wave_d = 1'b0;
            pend_d = 1'b0;
            note_d = note_i;
            oct_d  = oct_i;
            if (en_i && valid_note(note_i)) cnt_d = h_of(note_i, oct_i) - CNT_W'(1);
        end else begin
            if (en_q && !mute_q) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    pend_d = 1'b0;
                    if (pend_q && !valid_note(pnote_q)) begin
                        mute_d = 1'b1;
                        wave_d = 1'b0;
                    end else if (pend_q) begin
                        wave_d = ~wave_q;
                        note_d = pnote_q;
                        oct_d  = poct_q;
                        cnt_d  = h_of(pnote_q, poct_q) - CNT_W'(1);
                    end else begin
                        wave_d = ~wave_q;
                        cnt_d  = h_of(note_q, oct_q) - CNT_W'(1);
                    end
                end
            end
            if (wr_i) begin
                pend_d  = 1'b1;
                pnote_d = note_i;
                poct_d  = oct_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            mute_q  <= 1'b0;
            wave_q  <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            note_q  <= '0;
            oct_q   <= '0;
            pnote_q <= '0;
            poct_q  <= '0;
        end else begin
            en_q    <= en_d;
            mute_q  <= mute_d;
            wave_q  <= wave_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            note_q  <= note_d;
            oct_q   <= oct_d;
            pnote_q <= pnote_d;
            poct_q  <= poct_d;
        end
    end

    assign wave_o = wave_q;

endmodule

// File: rtl/poly_pitch_generator.sv
// N_CH-voice square-wave pitch generator: config decode, per-voice channels and
// a registered count of voices currently high.
module poly_pitch_generator
    import pitch_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CLK_HZ  = 100_000_000,
    parameter int CNT_W   = 22,
    parameter int MAX_OCT = 8,
    parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int MIX_W   = $clog2(N_CH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [3:0]       cfg_note,
    input  logic [3:0]       cfg_octave,
    input  logic             cfg_en,
    output logic [N_CH-1:0]  wave,
    output logic [MIX_W-1:0] mix
);

    logic             rdy_q;
    logic             acc;
    logic [3:0]       oct_c;
    logic [MIX_W-1:0] mix_q, mix_d;

    assign acc   = cfg_valid && rdy_q && (int'(cfg_ch) < N_CH);
    assign oct_c = (int'(cfg_octave) > MAX_OCT) ? 4'(MAX_OCT) : cfg_octave;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pitch_channel #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_i   (acc && (int'(cfg_ch) == g)),
            .note_i (cfg_note),
            .oct_i  (oct_c),
            .en_i   (cfg_en),
            .wave_o (wave[g])
        );
    end

    always_comb begin
        mix_d = '0;
        for (int i = 0; i < N_CH; i++) mix_d = mix_d + MIX_W'(wave[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            mix_q <= '0;
        end else begin
            rdy_q <= 1'b1;
            mix_q <= mix_d;
        end
    end

    assign cfg_ready = rdy_q;
    assign mix       = mix_q;

endmodule

// File: tb/tb_poly_pitch_generator.sv
// Directed bench for poly_pitch_generator at CLK_HZ = 1 MHz (A oct7 -> H=142).
module tb_poly_pitch_generator;

    localparam int N_CH  = 4;
    localparam int CH_W  = 3;
    localparam int MIX_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [3:0]       cfg_note;
    logic [3:0]       cfg_octave;
    logic             cfg_en;
    logic [N_CH-1:0]  wave;
    logic [MIX_W-1:0] mix;

    int checks   = 0;
    int failures = 0;

    poly_pitch_generator #(
        .N_CH(N_CH), .CLK_HZ(1_000_000), .CNT_W(22), .MAX_OCT(8), .CH_W(CH_W), .MIX_W(MIX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_note(cfg_note), .cfg_octave(cfg_octave), .cfg_en(cfg_en),
        .wave(wave), .mix(mix)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int note;
        int oct;
        int exp_h;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic write(input int ch, input int note, input int oct, input bit en);
        cfg_valid  = 1'b1;
        cfg_ch     = CH_W'(ch);
        cfg_note   = 4'(note);
        cfg_octave = 4'(oct);
        cfg_en     = en;
        step();
        cfg_valid  = 1'b0;
    endtask

    task automatic wait_wave(input int ch, input logic val, output int n);
        n = 0;
        while (wave[ch] !== val && n < 5000) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n, a, b, hi;
        vecs[0] = '{0, 9, 7, 142};
        vecs[1] = '{0, 9, 6, 284};
        vecs[2] = '{0, 9, 8, 71};
        vecs[3] = '{3, 9, 15, 71};
        vecs[4] = '{0, 0, 8, 119};
        vecs[5] = '{0, 7, 8, 79};

        rst_n = 1'b0;
        cfg_valid = 1'b1; cfg_ch = '0; cfg_note = 4'd9; cfg_octave = 4'd7; cfg_en = 1'b1;
        repeat (3) step();
        check("rst_wave", int'(wave), 0);
        check("rst_mix", int'(mix), 0);
        check("rst_ready", int'(cfg_ready), 0);
        cfg_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check("ready_after_rst", int'(cfg_ready), 1);

        foreach (vecs[i]) begin
            write(vecs[i].ch, 9, 7, 1'b0);
            write(vecs[i].ch, vecs[i].note, vecs[i].oct, 1'b1);
            wait_wave(vecs[i].ch, 1'b1, n);
            check($sformatf("vec%0d_rise", i), n, vecs[i].exp_h);
            wait_wave(vecs[i].ch, 1'b0, n);
            check($sformatf("vec%0d_fall", i), n, vecs[i].exp_h);
        end
        write(3, 9, 7, 1'b0);

        write(0, 9, 7, 1'b0);
        write(0, 9, 7, 1'b1);
        wait_wave(0, 1'b1, n);
        check("p_first_rise", n, 142);
        for (int i = 0; i < 10; i++) begin
            wait_wave(0, 1'b0, a);
            wait_wave(0, 1'b1, b);
            check($sformatf("period%0d", i), a + b, 284);
        end

        repeat (49) step();
        write(0, 9, 6, 1'b1);
        wait_wave(0, 1'b0, n);
        check("retune_cur_half", n, 92);
        wait_wave(0, 1'b1, n);
        check("retune_new_half_a", n, 284);
        wait_wave(0, 1'b0, n);
        check("retune_new_half_b", n, 284);
        write(0, 9, 8, 1'b1);
        write(0, 9, 7, 1'b1);
        wait_wave(0, 1'b1, n);
        check("b2b_cur_half", n, 282);
        wait_wave(0, 1'b0, n);
        check("b2b_last_wins_a", n, 142);
        wait_wave(0, 1'b1, n);
        check("b2b_last_wins_b", n, 142);

        write(1, 9, 7, 1'b0);
        write(1, 9, 7, 1'b1);
        wait_wave(1, 1'b1, n);
        wait_wave(1, 1'b0, n);
        write(1, 12, 7, 1'b1);
        hi = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (wave[1]) hi++;
        end
        check("mute_stays_low", hi, 0);
        write(1, 9, 8, 1'b1);
        wait_wave(1, 1'b1, n);
        check("mute_resume", n, 71);

        for (int c = 0; c < N_CH; c++) write(c, 9, 7, 1'b0);
        write(5, 9, 8, 1'b1);
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (wave != '0) hi++;
        end
        check("bad_ch_ignored", hi, 0);

        for (int c = 0; c < N_CH; c++) write(c, 9, 7, 1'b1);
        repeat (139) step();
        check("mix_w0", int'(wave), 4'b0001);
        check("mix_m0", int'(mix), 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("mix_ramp%0d", k), int'(mix), k);
        end
        write(2, 9, 7, 1'b0);
        check("dis_wave", int'(wave), 4'b1011);
        check("dis_mix_lag", int'(mix), 4);
        step();
        check("dis_mix", int'(mix), 3);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_wave", int'(wave), 0);
        check("mid_rst_mix", int'(mix), 0);
        check("mid_rst_ready", int'(cfg_ready), 0);
        hi = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (wave != '0 || mix != '0) hi++;
        end
        check("post_rst_quiet", hi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
